wb_bus_decoder: RTL and testbench

Parametrised Wishbone B4 pipelined single-master interconnect that routes one master (picorv32 wishbone adapter) to `NS` slaves. Address decode uses per-slave base/mask pairs, and only one transaction is outstanding at a time. Responses are registered and returned to the master. The block adds a per-transaction timeout watchdog and faulting-address capture, and replaces the fixed three-slave equality decoder in the SoC top level.

---
 rtl/wb_bus_decoder_if.sv | 36 +++
 rtl/wb_bus_decoder.sv | 197 +++++++++++++++++++
 tb/tb_wb_bus_decoder.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bus_decoder_if.sv
// ---------------------------------------------------------------------------
// wb_bus_decoder_if
// Wishbone B4 pipelined master-side bus between the single master and the
// wb_bus_decoder interconnect.
//   i_wb_addr/i_wb_data/i_wb_sel/i_wb_we/i_wb_cyc/i_wb_stb : master request
//   o_wb_ack/o_wb_data/o_wb_stall/o_wb_err                 : decoder response
// Modports:
//   master : the bus master (drives the request, observes the response)
//   slave  : the decoder (observes the request, drives the response)
// ---------------------------------------------------------------------------
interface wb_bus_decoder_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   i_wb_addr;
    logic [DW-1:0]   i_wb_data;
    logic [DW/8-1:0] i_wb_sel;
    logic            i_wb_we;
    logic            i_wb_cyc;
    logic            i_wb_stb;

    logic            o_wb_ack;
    logic [DW-1:0]   o_wb_data;
    logic            o_wb_stall;
    logic            o_wb_err;

    modport master (
        output i_wb_addr, i_wb_data, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
        input  o_wb_ack, o_wb_data, o_wb_stall, o_wb_err
    );

    modport slave (
        input  i_wb_addr, i_wb_data, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
        output o_wb_ack, o_wb_data, o_wb_stall, o_wb_err
    );
endinterface

// File: rtl/wb_bus_decoder.sv
// ---------------------------------------------------------------------------
// wb_bus_decoder
// Single-master Wishbone B4 pipelined interconnect routing one master to NS
// slaves. Slave k is selected when (addr & MASK_k) == BASE_k, lowest k wins.
// One transaction outstanding at a time; the slave response is registered
// and shown to the master for one cycle. Decode misses and slave errors
// return a bus error and record the faulting address.
//
// Optional feature macro: WB_BUS_DECODER_TIMEOUT_EN
//   When defined, a 16-bit watchdog counts BUSY cycles and raises a bus
//   error after TIMEOUT cycles without a slave response. When undefined no
//   counter exists and BUSY waits for the slave or for the master to abort.
//
// Ports:
//   i_clk, i_resetn   : clock, asynchronous active-low reset
//   wb (slave)        : master-side Wishbone bus (request in, response out)
//   o_wb_err_address  : address of the most recent errored transaction
//   o_s_stb[NS]       : per-slave strobe (addr/data/sel/we/cyc are
//                       broadcast to the slaves by wiring, unchanged)
//   i_s_ack/err/stall : per-slave responses
//   i_s_data[NS*DW]   : packed slave read data, slave k at [k*DW +: DW]
// ---------------------------------------------------------------------------
module wb_bus_decoder #(
    parameter int                NS         = 4,
    parameter int                AW         = 32,
    parameter int                DW         = 32,
    parameter logic [NS*AW-1:0]  SLAVE_BASE = '0,
    parameter logic [NS*AW-1:0]  SLAVE_MASK = '1,
    parameter int                TIMEOUT    = 255
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    wb_bus_decoder_if.slave  wb,
    output logic [AW-1:0]    o_wb_err_address,
    output logic [NS-1:0]    o_s_stb,
    input  logic [NS-1:0]    i_s_ack,
    input  logic [NS-1:0]    i_s_err,
    input  logic [NS-1:0]    i_s_stall,
    input  logic [NS*DW-1:0] i_s_data
);
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [AW-1:0] req_addr_q;
    logic [AW-1:0] err_addr_q;
    logic          ack_q;
    logic          err_q;
    logic [DW-1:0] data_q;
`ifdef WB_BUS_DECODER_TIMEOUT_EN
    logic [15:0]   cnt_q;
`endif

    logic [NS-1:0] hit;
    logic          hit_any;
    logic [IW-1:0] win_d;
    logic          win_stall;
    logic          stall_d;
    logic          accept_d;
    logic          sel_ack;
    logic          sel_err;
    logic [DW-1:0] sel_data;

    // Address decode against every base/mask pair.
    always_comb begin
        hit = '0;
        for (int k = 0; k < NS; k++)
            hit[k] = ((wb.i_wb_addr & SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW]);
    end

    assign hit_any = |hit;

    // Priority pick: scanning downward lets the lowest matching slave
    // overwrite any higher one.
    always_comb begin
        win_d     = '0;
        win_stall = 1'b0;
        for (int k = NS - 1; k >= 0; k--) begin
            if (hit[k]) begin
                win_d     = IW'(k);
                win_stall = i_s_stall[k];
            end
        end
    end

    always_comb begin
        o_s_stb = '0;
        for (int k = 0; k < NS; k++)
            o_s_stb[k] = (state_q == IDLE) && wb.i_wb_cyc && wb.i_wb_stb &&
                         hit_any && (win_d == IW'(k));
    end

    // A miss never stalls: it is accepted and answered with an error.
    assign stall_d  = (state_q != IDLE) || (hit_any && win_stall);
    assign accept_d = (state_q == IDLE) && wb.i_wb_cyc && wb.i_wb_stb && !stall_d;

    // Only the latched slave's response lines are looked at.
    always_comb begin
        sel_ack  = 1'b0;
        sel_err  = 1'b0;
        sel_data = '0;
        for (int k = 0; k < NS; k++) begin
            if (idx_q == IW'(k)) begin
                sel_ack  = i_s_ack[k];
                sel_err  = i_s_err[k];
                sel_data = i_s_data[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            req_addr_q <= '0;
            err_addr_q <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
`ifdef WB_BUS_DECODER_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            // Response flags and data are single-cycle pulses.
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        req_addr_q <= wb.i_wb_addr;
                        if (hit_any) begin
                            idx_q   <= win_d;
                            state_q <= BUSY;
`ifdef WB_BUS_DECODER_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end else begin
                            err_q      <= 1'b1;
                            err_addr_q <= wb.i_wb_addr;
                            state_q    <= RESP;
                        end
                    end
                end
                BUSY: begin
                    // Abort outranks any response; err outranks ack; a
                    // real response outranks the watchdog.
                    if (!wb.i_wb_cyc) begin
                        state_q <= IDLE;
`ifdef WB_BUS_DECODER_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end else if (sel_err) begin
                        err_q      <= 1'b1;
                        err_addr_q <= req_addr_q;
                        state_q    <= RESP;
                    end else if (sel_ack) begin
                        ack_q   <= 1'b1;
                        data_q  <= sel_data;
                        state_q <= RESP;
                    end
`ifdef WB_BUS_DECODER_TIMEOUT_EN
                    // Fires in the BUSY cycle whose increment would
                    // reach TIMEOUT, i.e. after TIMEOUT BUSY cycles.
                    else if (cnt_q == 16'(TIMEOUT - 1)) begin
                        err_q      <= 1'b1;
                        err_addr_q <= req_addr_q;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`endif
                end
                RESP: begin
                    state_q <= IDLE;
`ifdef WB_BUS_DECODER_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb.o_wb_ack   = ack_q;
    assign wb.o_wb_err   = err_q;
    assign wb.o_wb_data  = data_q;
    assign wb.o_wb_stall = stall_d;
    assign o_wb_err_address = err_addr_q;

endmodule

// File: tb/tb_wb_bus_decoder.sv
module tb_wb_bus_decoder;
    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [NS*AW-1:0] BASES = {32'h8000_0020, 32'h8000_0010, 32'h8000_0000};
    localparam logic [NS*AW-1:0] MASKS = {3{32'hFFFF_FFF0}};

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic [AW-1:0]    err_address;
    logic [NS-1:0]    s_stb;
    logic [NS-1:0]    s_ack   = '0;
    logic [NS-1:0]    s_err   = '0;
    logic [NS-1:0]    s_stall = '0;
    logic [NS*DW-1:0] s_data  = '0;

    int total = 0;
    int bad   = 0;

    wb_bus_decoder_if #(.AW(AW), .DW(DW)) bus ();

    wb_bus_decoder #(
        .NS(NS), .AW(AW), .DW(DW),
        .SLAVE_BASE(BASES), .SLAVE_MASK(MASKS), .TIMEOUT(8)
    ) dut (
        .i_clk(clk),
        .i_resetn(rstn),
        .wb(bus),
        .o_wb_err_address(err_address),
        .o_s_stb(s_stb),
        .i_s_ack(s_ack),
        .i_s_err(s_err),
        .i_s_stall(s_stall),
        .i_s_data(s_data)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: first slave whose masked address equals its base.
    function automatic int ref_target(input logic [AW-1:0] a);
        for (int k = 0; k < NS; k++)
            if ((a & MASKS[k*AW +: AW]) == BASES[k*AW +: AW]) return k;
        return -1;
    endfunction

    logic [AW-1:0] m_err_addr;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp_d;
    logic [NS-1:0] e_stb;
    int            tgt, lat, rt, pick;

    initial begin
        bus.i_wb_addr = '0; bus.i_wb_data = '0; bus.i_wb_sel = '0;
        bus.i_wb_we = 1'b0; bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
        m_err_addr = '0;

        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack",   bus.o_wb_ack, 0);
        chk("rst_err",   bus.o_wb_err, 0);
        chk("rst_data",  bus.o_wb_data, 0);
        chk("rst_eaddr", err_address, 0);
        chk("rst_stb",   s_stb, 0);
        chk("rst_stall", bus.o_wb_stall, 0);
        rstn = 1'b1;
        tick;

        // ---- read slave 1, ack two cycles after strobe; slave 0 acks too
        bus.i_wb_addr = 32'h8000_0014; bus.i_wb_we = 1'b0;
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
        #1;
        chk("rd_stb", s_stb, 3'b010);
        chk("rd_stall_idle", bus.o_wb_stall, 0);
        tick;
        bus.i_wb_stb = 1'b0;
        #1;
        chk("rd_busy_stb", s_stb, 0);
        chk("rd_busy_stall", bus.o_wb_stall, 1);
        tick;
        s_ack = 3'b011;
        s_data = {32'h0000_0000, 32'hA5A5_0001, 32'hDEAD_0000};
        tick;
        s_ack = '0; s_data = '0;
        chk("rd_ack", bus.o_wb_ack, 1);
        chk("rd_data", bus.o_wb_data, 32'hA5A5_0001);
        chk("rd_err", bus.o_wb_err, 0);
        tick;
        chk("rd_ack_once", bus.o_wb_ack, 0);
        chk("rd_data_idle", bus.o_wb_data, 0);
        bus.i_wb_cyc = 1'b0;
        tick;

        // ---- decode miss
        bus.i_wb_addr = 32'h9000_0000; bus.i_wb_we = 1'b1;
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
        #1;
        chk("miss_stb", s_stb, 0);
        chk("miss_stall", bus.o_wb_stall, 0);
        tick;
        bus.i_wb_stb = 1'b0;
        chk("miss_err", bus.o_wb_err, 1);
        chk("miss_ack", bus.o_wb_ack, 0);
        chk("miss_data", bus.o_wb_data, 0);
        chk("miss_eaddr", err_address, 32'h9000_0000);
        tick;
        chk("miss_err_once", bus.o_wb_err, 0);
        chk("miss_eaddr_hold", err_address, 32'h9000_0000);
        bus.i_wb_cyc = 1'b0;
        tick;

        // ---- slave 2 stalls 3 cycles, then ack+err together
        bus.i_wb_addr = 32'h8000_0024; bus.i_wb_we = 1'b0;
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
        s_stall = 3'b100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_hi", bus.o_wb_stall, 1);
            chk("stall_stb", s_stb, 3'b100);
            tick;
        end
        s_stall = '0;
        #1;
        chk("stall_lo", bus.o_wb_stall, 0);
        chk("stall_accept_stb", s_stb, 3'b100);
        tick;
        bus.i_wb_stb = 1'b0;
        #1;
        chk("stall_busy", bus.o_wb_stall, 1);
        s_ack = 3'b100; s_err = 3'b100; s_data = {32'h1111_2222, 64'h0};
        tick;
        s_ack = '0; s_err = '0; s_data = '0;
        chk("ackerr_err", bus.o_wb_err, 1);
        chk("ackerr_ack", bus.o_wb_ack, 0);
        chk("ackerr_data", bus.o_wb_data, 0);
        chk("ackerr_eaddr", err_address, 32'h8000_0024);
        m_err_addr = 32'h8000_0024;
        tick;
        bus.i_wb_cyc = 1'b0;
        tick;

        // ---- unresponsive slave 0
        bus.i_wb_addr = 32'h8000_0008;
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
        tick;
        bus.i_wb_stb = 1'b0;
`ifdef WB_BUS_DECODER_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            chk("to_wait_err", bus.o_wb_err, 0);
            tick;
        end
        chk("to_err", bus.o_wb_err, 1);
        chk("to_eaddr", err_address, 32'h8000_0008);
        m_err_addr = 32'h8000_0008;
        tick;
        chk("to_idle_err", bus.o_wb_err, 0);
        chk("to_idle_stall", bus.o_wb_stall, 0);
        bus.i_wb_cyc = 1'b0;
        tick;
`else
        for (int i = 0; i < 20; i++) begin
            chk("hang_err", bus.o_wb_err, 0);
            chk("hang_ack", bus.o_wb_ack, 0);
            chk("hang_stall", bus.o_wb_stall, 1);
            tick;
        end
        bus.i_wb_cyc = 1'b0;
        tick;
        chk("hang_abort_stall", bus.o_wb_stall, 0);
        chk("hang_abort_err", bus.o_wb_err, 0);
        chk("hang_eaddr", err_address, m_err_addr);
`endif

        // ---- abort coinciding with slave ack, then a normal request
        bus.i_wb_addr = 32'h8000_0014;
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
        tick;
        bus.i_wb_stb = 1'b0;
        bus.i_wb_cyc = 1'b0; s_ack = 3'b010; s_data = {32'h0, 32'hBEEF_0000, 32'h0};
        tick;
        s_ack = '0; s_data = '0;
        chk("abort_ack", bus.o_wb_ack, 0);
        chk("abort_err", bus.o_wb_err, 0);
        chk("abort_stall", bus.o_wb_stall, 0);
        tick;
        chk("abort_ack2", bus.o_wb_ack, 0);
        bus.i_wb_addr = 32'h8000_0004;
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
        #1;
        chk("post_abort_stb", s_stb, 3'b001);
        tick;
        bus.i_wb_stb = 1'b0;
        s_ack = 3'b001; s_data = {64'h0, 32'h1234_5678};
        tick;
        s_ack = '0; s_data = '0;
        chk("post_abort_ack", bus.o_wb_ack, 1);
        chk("post_abort_data", bus.o_wb_data, 32'h1234_5678);
        tick;
        bus.i_wb_cyc = 1'b0;
        tick;

        // ---- reset asserted mid-BUSY
        bus.i_wb_addr = 32'h8000_0018;
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
        tick;
        bus.i_wb_stb = 1'b0;
        #1;
        chk("rb_busy", bus.o_wb_stall, 1);
        rstn = 1'b0;
        #1;
        chk("rb_ack", bus.o_wb_ack, 0);
        chk("rb_err", bus.o_wb_err, 0);
        chk("rb_data", bus.o_wb_data, 0);
        chk("rb_eaddr", err_address, 0);
        chk("rb_stall", bus.o_wb_stall, 0);
        chk("rb_stb", s_stb, 0);
        m_err_addr = '0;
        bus.i_wb_cyc = 1'b0;
        tick;
        rstn = 1'b1;
        tick;
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
        #1;
        chk("rb_post_stb", s_stb, 3'b010);
        tick;
        bus.i_wb_stb = 1'b0;
        s_ack = 3'b010; s_data = {32'h0, 32'h0BAD_F00D, 32'h0};
        tick;
        s_ack = '0; s_data = '0;
        chk("rb_post_ack", bus.o_wb_ack, 1);
        chk("rb_post_data", bus.o_wb_data, 32'h0BAD_F00D);
        tick;
        bus.i_wb_cyc = 1'b0;
        tick;

        // ---- randomized transactions against the reference decode model
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 3);
            if (pick < 3) ra = 32'h8000_0000 + 32'(pick * 16) + 32'($urandom_range(0, 15));
            else          ra = $urandom;
            tgt = ref_target(ra);
            e_stb = '0;
            if (tgt >= 0) e_stb[tgt] = 1'b1;
            bus.i_wb_addr = ra; bus.i_wb_we = 1'($urandom_range(0, 1));
            bus.i_wb_data = $urandom; bus.i_wb_sel = 4'($urandom_range(0, 15));
            bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
            #1;
            chk("rnd_stb", s_stb, e_stb);
            chk("rnd_stall", bus.o_wb_stall, 0);
            tick;
            bus.i_wb_stb = 1'b0;
            if (tgt < 0) begin
                m_err_addr = ra;
                chk("rnd_miss_err", bus.o_wb_err, 1);
                chk("rnd_miss_ack", bus.o_wb_ack, 0);
            end else begin
                lat = $urandom_range(0, 3);
                for (int i = 0; i < lat; i++) begin
                    s_ack = 3'($urandom_range(0, 7)) & ~e_stb;
                    s_err = 3'($urandom_range(0, 7)) & ~e_stb;
                    s_data = {$urandom, $urandom, $urandom};
                    tick;
                    chk("rnd_wait_ack", bus.o_wb_ack, 0);
                    chk("rnd_wait_err", bus.o_wb_err, 0);
                end
                rt = $urandom_range(0, 3);
                s_ack = 3'($urandom_range(0, 7)) & ~e_stb;
                s_err = 3'($urandom_range(0, 7)) & ~e_stb;
                s_data = {$urandom, $urandom, $urandom};
                if (rt != 2) s_ack = s_ack | e_stb;
                if (rt >= 2) s_err = s_err | e_stb;
                exp_d = s_data[tgt*DW +: DW];
                tick;
                s_ack = '0; s_err = '0; s_data = '0;
                if (rt >= 2) begin
                    m_err_addr = ra;
                    chk("rnd_err", bus.o_wb_err, 1);
                    chk("rnd_err_ack", bus.o_wb_ack, 0);
                    chk("rnd_err_data", bus.o_wb_data, 0);
                end else begin
                    chk("rnd_ack", bus.o_wb_ack, 1);
                    chk("rnd_ack_err", bus.o_wb_err, 0);
                    chk("rnd_ack_data", bus.o_wb_data, exp_d);
                end
            end
            chk("rnd_eaddr", err_address, m_err_addr);
            tick;
            chk("rnd_idle_ack", bus.o_wb_ack, 0);
            chk("rnd_idle_err", bus.o_wb_err, 0);
            bus.i_wb_cyc = 1'b0;
            tick;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
